// File: rtl/mem_mp.sv
`default_nettype none
// ============================================================================
// Module : mem_mp
// Multi-read / single-write word memory with byte-enable writes, selectable
// read-during-write forwarding and a post-reset clear sequencer.
// Rev    : 1.0
// ============================================================================
module mem_mp #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 16,
  parameter int NUM_RD         = 2,
  parameter bit BYPASS         = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       init_busy,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_be
);

  localparam int              c_NB      = DATA_W / 8;
  localparam int              c_DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] c_LAST    = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [0:0]      c_S_CLEAR = 1'b0;
  localparam logic [0:0]      c_S_RUN   = 1'b1;
  localparam logic [0:0]      c_S_RESET = CLEAR_ON_RESET ? c_S_CLEAR : c_S_RUN;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ADDR_W:0]   r_cnt;
  logic              w_clear;
  logic              w_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_S_RESET;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == c_S_CLEAR && r_cnt == c_LAST) w_state_nxt = c_S_RUN;
  end

  always_comb begin
    w_clear = (r_state == c_S_CLEAR);
    w_run   = (r_state == c_S_RUN);
  end

  assign init_busy = w_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_cnt <= '0;
    else if (w_clear) r_cnt <= r_cnt + 1'b1;
  end

  // The clear sequencer owns the single array write port until RUN.
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic [c_NB-1:0]   w_mem_be;

  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = wr_addr;
    w_mem_data = wr_data;
    w_mem_be   = wr_be;
    if (w_clear) begin
      w_mem_we   = rst_n;
      w_mem_addr = r_cnt[ADDR_W-1:0];
      w_mem_data = '0;
      w_mem_be   = '1;
    end else if (w_run) begin
      w_mem_we   = rst_n & wr_en;
    end
  end

  logic [DATA_W-1:0] r_mem [c_DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < c_NB; b++) begin
      if (w_mem_we && w_mem_be[b]) r_mem[w_mem_addr][b*8 +: 8] <= w_mem_data[b*8 +: 8];
    end
  end

  // Read word per port, with write-first byte merge on an address hit.
  logic [DATA_W-1:0] w_rd_word [NUM_RD];

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      w_rd_word[p] = r_mem[rd_addr[p*ADDR_W +: ADDR_W]];
      if (BYPASS && w_run && wr_en && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W])) begin
        for (int b = 0; b < c_NB; b++) begin
          if (wr_be[b]) w_rd_word[p][b*8 +: 8] = wr_data[b*8 +: 8];
        end
      end
    end
  end

  logic [DATA_W-1:0] r_rd_data [NUM_RD];
  logic [NUM_RD-1:0] r_rd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= '0;
      for (int p = 0; p < NUM_RD; p++) r_rd_data[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        r_rd_valid[p] <= w_run & rd_en[p];
        if (w_run && rd_en[p]) r_rd_data[p] <= w_rd_word[p];
      end
    end
  end

  assign rd_valid = r_rd_valid;

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_pack
      assign rd_data[p*DATA_W +: DATA_W] = r_rd_data[p];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_mp.sv
`default_nettype none
// Bench for mem_mp: write-first and read-first 2-port builds driven in
// lockstep, plus a 4-port build for independent per-port enables.
module tb_mem_mp;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;

  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_valid_a, rd_valid_b;
  logic        busy_a, busy_b;

  logic        wr_en4;
  logic [3:0]  wr_addr4;
  logic [31:0] wr_data4;
  logic [3:0]  wr_be4;
  logic [3:0]  rd_en4;
  logic [15:0] rd_addr4;
  logic [127:0] rd_data4;
  logic [3:0]  rd_valid4;
  logic        busy4;

  always #5 clk = ~clk;

  mem_mp #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .init_busy(busy_a),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be));

  mem_mp #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .BYPASS(1'b0), .CLEAR_ON_RESET(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .init_busy(busy_b),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be));

  mem_mp #(.DATA_W(32), .ADDR_W(4), .NUM_RD(4), .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1)) dut_4 (
    .clk(clk), .rst_n(rst_n), .init_busy(busy4),
    .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_data(rd_data4), .rd_valid(rd_valid4),
    .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4), .wr_be(wr_be4));

  typedef struct {
    int          port;
    logic [31:0] da;   // write-first build
    logic [31:0] db;   // read-first build
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl [16];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic idle();
    wr_en  = 1'b0;
    rd_en  = 2'b00;
    wr_en4 = 1'b0;
    rd_en4 = 4'b0000;
  endtask

  task automatic wr_drive(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic rd_drive(input int p, input logic [3:0] a);
    rd_en[p] = 1'b1;
    rd_addr[p*4 +: 4] = a;
  endtask

  task automatic push_exp(input int p, input logic [31:0] da, input logic [31:0] db);
    exp_t e;
    e.port = p; e.da = da; e.db = db;
    sbq.push_back(e);
  endtask

  // One active edge; the reference array follows the write port.
  task automatic tick();
    @(posedge clk);
    if (wr_en) mdl[wr_addr] = merge(mdl[wr_addr], wr_data, wr_be);
    #1;
  endtask

  task automatic test_reset();
    int cyc;
    idle();
    wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
    wr_addr4 = '0; wr_data4 = '0; wr_be4 = '0; rd_addr4 = '0;
    #1 rst_n = 1'b0;
    #21;
    n_cmp++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1 || busy4 !== 1'b1) begin
      n_err++; $display("FAIL reset_busy: got %b%b%b, required 111", busy_a, busy_b, busy4);
    end
    n_cmp++;
    if (rd_valid_a !== 2'b00 || rd_data_a !== 64'h0 || rd_valid4 !== 4'h0 || rd_data4 !== 128'h0) begin
      n_err++; $display("FAIL reset_rd: got valid %b data %h, required 0/0", rd_valid_a, rd_data_a);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Traffic during the clear must be ignored entirely.
    wr_drive(4'd2, 32'hFFFF_FFFF, 4'hF);
    rd_en = 2'b11; rd_addr = {4'd2, 4'd2};
    cyc = 0;
    while (busy_a && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      n_cmp++;
      if (rd_valid_a !== 2'b00 || rd_valid_b !== 2'b00 || rd_data_a !== 64'h0) begin
        n_err++; $display("FAIL clear_ignore cyc %0d: got valid %b data %h, required 00/0", cyc, rd_valid_a, rd_data_a);
      end
    end
    idle();
    n_cmp++;
    if (cyc != 16) begin
      n_err++; $display("FAIL clear_len: got %0d cycles busy, required 16", cyc);
    end
    n_cmp++;
    if (busy_b !== 1'b0 || busy4 !== 1'b0) begin
      n_err++; $display("FAIL clear_done: got busy_b %b busy4 %b, required 0 0", busy_b, busy4);
    end
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
  endtask

  task automatic test_clear_contents();
    exp_t e;
    for (int c = 0; c < 33; c++) begin
      idle();
      if (c % 2 == 0 && c < 32) begin
        rd_drive(0, 4'(c / 2));
        rd_drive(1, 4'(15 - c / 2));
        push_exp(0, 32'h0, 32'h0);
        push_exp(1, 32'h0, 32'h0);
      end
      tick();
      for (int p = 0; p < 2; p++) begin
        if (rd_valid_a[p] || rd_valid_b[p]) begin
          n_cmp++;
          if (sbq.size() == 0) begin
            n_err++; $display("FAIL clear_rd port %0d: got unexpected valid a=%b b=%b, required none", p, rd_valid_a[p], rd_valid_b[p]);
          end else begin
            e = sbq.pop_front();
            if (e.port != p || rd_valid_a[p] !== 1'b1 || rd_valid_b[p] !== 1'b1 ||
                rd_data_a[p*32 +: 32] !== e.da || rd_data_b[p*32 +: 32] !== e.db) begin
              n_err++; $display("FAIL clear_rd port %0d: got %h/%h, required %h/%h (port %0d)", p, rd_data_a[p*32 +: 32], rd_data_b[p*32 +: 32], e.da, e.db, e.port);
            end
          end
        end
      end
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++; $display("FAIL clear_rd_missing: got %0d reads unanswered, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_byte_enable();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      idle();
      case (c)
        0: wr_drive(4'd3, 32'hDEAD_BEEF, 4'b1111);
        1: wr_drive(4'd3, 32'h1122_3344, 4'b0101);
        2: begin rd_drive(0, 4'd3); push_exp(0, 32'hDE22_BE44, 32'hDE22_BE44); end
        default: ;
      endcase
      tick();
      for (int p = 0; p < 2; p++) begin
        if (rd_valid_a[p] || rd_valid_b[p]) begin
          n_cmp++;
          if (sbq.size() == 0) begin
            n_err++; $display("FAIL byte_en port %0d: got unexpected valid a=%b b=%b, required none", p, rd_valid_a[p], rd_valid_b[p]);
          end else begin
            e = sbq.pop_front();
            if (e.port != p || rd_valid_a[p] !== 1'b1 || rd_valid_b[p] !== 1'b1 ||
                rd_data_a[p*32 +: 32] !== e.da || rd_data_b[p*32 +: 32] !== e.db) begin
              n_err++; $display("FAIL byte_en port %0d: got %h/%h, required %h/%h", p, rd_data_a[p*32 +: 32], rd_data_b[p*32 +: 32], e.da, e.db);
            end
          end
        end
      end
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++; $display("FAIL byte_en_missing: got %0d reads unanswered, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_collision();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      idle();
      case (c)
        0: wr_drive(4'd5, 32'hAAAA_AAAA, 4'b1111);
        1: begin
          wr_drive(4'd5, 32'h1234_5678, 4'b0011);
          rd_drive(0, 4'd5); rd_drive(1, 4'd5);
          push_exp(0, 32'hAAAA_5678, 32'hAAAA_AAAA);
          push_exp(1, 32'hAAAA_5678, 32'hAAAA_AAAA);
        end
        2: begin
          rd_drive(0, 4'd5); rd_drive(1, 4'd5);
          push_exp(0, 32'hAAAA_5678, 32'hAAAA_5678);
          push_exp(1, 32'hAAAA_5678, 32'hAAAA_5678);
        end
        default: ;
      endcase
      tick();
      for (int p = 0; p < 2; p++) begin
        if (rd_valid_a[p] || rd_valid_b[p]) begin
          n_cmp++;
          if (sbq.size() == 0) begin
            n_err++; $display("FAIL collide port %0d: got unexpected valid a=%b b=%b, required none", p, rd_valid_a[p], rd_valid_b[p]);
          end else begin
            e = sbq.pop_front();
            if (e.port != p || rd_valid_a[p] !== 1'b1 || rd_valid_b[p] !== 1'b1 ||
                rd_data_a[p*32 +: 32] !== e.da || rd_data_b[p*32 +: 32] !== e.db) begin
              n_err++; $display("FAIL collide port %0d cyc %0d: got %h/%h, required %h/%h", p, c, rd_data_a[p*32 +: 32], rd_data_b[p*32 +: 32], e.da, e.db);
            end
          end
        end
      end
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++; $display("FAIL collide_missing: got %0d reads unanswered, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  // Random mixed traffic every cycle, including zero byte enables and hits.
  task automatic test_back_to_back();
    exp_t        e;
    logic [3:0]  a;
    for (int c = 0; c < 61; c++) begin
      idle();
      if (c < 60) begin
        if ($urandom_range(0, 2) != 0)
          wr_drive(4'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
        for (int p = 0; p < 2; p++) begin
          if ($urandom_range(0, 3) != 0) begin
            a = 4'($urandom_range(0, 7));
            rd_drive(p, a);
            push_exp(p, (wr_en && wr_addr == a) ? merge(mdl[a], wr_data, wr_be) : mdl[a], mdl[a]);
          end
        end
      end
      tick();
      for (int p = 0; p < 2; p++) begin
        if (rd_valid_a[p] || rd_valid_b[p]) begin
          n_cmp++;
          if (sbq.size() == 0) begin
            n_err++; $display("FAIL b2b port %0d: got unexpected valid a=%b b=%b, required none", p, rd_valid_a[p], rd_valid_b[p]);
          end else begin
            e = sbq.pop_front();
            if (e.port != p || rd_valid_a[p] !== 1'b1 || rd_valid_b[p] !== 1'b1 ||
                rd_data_a[p*32 +: 32] !== e.da || rd_data_b[p*32 +: 32] !== e.db) begin
              n_err++; $display("FAIL b2b port %0d cyc %0d: got %h/%h, required %h/%h (port %0d)", p, c, rd_data_a[p*32 +: 32], rd_data_b[p*32 +: 32], e.da, e.db, e.port);
            end
          end
        end
      end
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++; $display("FAIL b2b_missing: got %0d reads unanswered, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_hold_and_async_reset();
    idle();
    wr_drive(4'd5, 32'hCAFE_F00D, 4'hF);
    tick();
    idle();
    rd_drive(0, 4'd5);
    tick();
    idle();
    n_cmp++;
    if (rd_valid_a !== 2'b01 || rd_data_a[31:0] !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL hold_read: got valid %b data %h, required 01 cafef00d", rd_valid_a, rd_data_a[31:0]);
    end
    tick();
    n_cmp++;
    if (rd_valid_a !== 2'b00 || rd_data_a[31:0] !== 32'hCAFE_F00D || rd_data_b[31:0] !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL hold_idle: got valid %b data %h/%h, required 00 cafef00d", rd_valid_a, rd_data_a[31:0], rd_data_b[31:0]);
    end
    rd_drive(0, 4'd5);
    tick();
    idle();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (rd_valid_a !== 2'b00 || rd_data_a !== 64'h0 || rd_data_b !== 64'h0 || busy_a !== 1'b1) begin
      n_err++; $display("FAIL async_reset: got valid %b data %h busy %b, required 00 0 1", rd_valid_a, rd_data_a, busy_a);
    end
  endtask

  // Entered with rst_n low; pulses reset again at clear cycle 7.
  task automatic test_reset_mid_clear();
    exp_t e;
    int   cyc;
    int   low_busy;
    @(posedge clk); #1;
    rst_n = 1'b1;
    low_busy = 0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (busy_a !== 1'b1) low_busy++;
    end
    n_cmp++;
    if (low_busy != 0) begin
      n_err++; $display("FAIL midclr_busy: got %0d early drops, required 0", low_busy);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;
    while (busy_a && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (cyc != 16) begin
      n_err++; $display("FAIL midclr_len: got %0d cycles busy, required 16", cyc);
    end
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    for (int c = 0; c < 2; c++) begin
      idle();
      if (c == 0) begin
        rd_drive(0, 4'd5); rd_drive(1, 4'd3);
        push_exp(0, 32'h0, 32'h0);
        push_exp(1, 32'h0, 32'h0);
      end
      tick();
      for (int p = 0; p < 2; p++) begin
        if (rd_valid_a[p] || rd_valid_b[p]) begin
          n_cmp++;
          if (sbq.size() == 0) begin
            n_err++; $display("FAIL midclr_rd port %0d: got unexpected valid, required none", p);
          end else begin
            e = sbq.pop_front();
            if (e.port != p || rd_valid_a[p] !== 1'b1 || rd_valid_b[p] !== 1'b1 ||
                rd_data_a[p*32 +: 32] !== e.da || rd_data_b[p*32 +: 32] !== e.db) begin
              n_err++; $display("FAIL midclr_rd port %0d: got %h/%h, required %h/%h", p, rd_data_a[p*32 +: 32], rd_data_b[p*32 +: 32], e.da, e.db);
            end
          end
        end
      end
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++; $display("FAIL midclr_missing: got %0d reads unanswered, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_multi_port();
    logic [31:0] exp4 [4];
    for (int i = 0; i < 8; i++) begin
      idle();
      wr_en4 = 1'b1; wr_addr4 = 4'(i); wr_be4 = 4'hF;
      wr_data4 = (i < 4) ? 32'(10 + i) : 32'(16 + i);
      @(posedge clk); #1;
    end
    idle();
    rd_en4   = 4'b1111;
    rd_addr4 = {4'd7, 4'd6, 4'd5, 4'd4};
    @(posedge clk); #1;
    idle();
    exp4[0] = 32'd20; exp4[1] = 32'd21; exp4[2] = 32'd22; exp4[3] = 32'd23;
    n_cmp++;
    if (rd_valid4 !== 4'b1111) begin
      n_err++; $display("FAIL mp_all_valid: got %b, required 1111", rd_valid4);
    end
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (rd_data4[p*32 +: 32] !== exp4[p]) begin
        n_err++; $display("FAIL mp_all port %0d: got %0d, required %0d", p, rd_data4[p*32 +: 32], exp4[p]);
      end
    end
    rd_en4   = 4'b1010;
    rd_addr4 = {4'd3, 4'd2, 4'd1, 4'd0};
    @(posedge clk); #1;
    idle();
    exp4[1] = 32'd11; exp4[3] = 32'd13;
    n_cmp++;
    if (rd_valid4 !== 4'b1010) begin
      n_err++; $display("FAIL mp_sel_valid: got %b, required 1010", rd_valid4);
    end
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (rd_data4[p*32 +: 32] !== exp4[p]) begin
        n_err++; $display("FAIL mp_sel port %0d: got %0d, required %0d", p, rd_data4[p*32 +: 32], exp4[p]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear_contents();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_hold_and_async_reset();
    test_reset_mid_clear();
    test_multi_port();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
